knn_vote: RTL and testbench

Majority-vote classifier on the read-out side of the KNN nearest-neighbour sorter. On `start`, once the sorter has finished inserting, it walks the sorter's `SEL` port over the K stored neighbours and fetches each neighbour's class label from an external label memory. It tallies the votes and returns the winning class over a valid/ack handshake. It sits between the sorter's index output and the peripheral register bank.

---
 rtl/knn_vote.sv | 139 +++++++++++++
 tb/tb_knn_vote.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier behind the KNN nearest-neighbour sorter.
//
// On start, walks the sorter's SEL port over the K stored neighbours. It reads
// each neighbour's class label from an external label memory and counts the
// votes per class. It then scans the vote counters in ascending class order;
// ties resolve to the lowest class. The winning class is presented on a
// valid/ack handshake.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   start        begin a vote (sampled only while idle)
//   sel          neighbour slot select, driven to the sorter
//   idx_in       neighbour index from the sorter (combinational on sel)
//   lbl_addr     label memory address
//   lbl_rd       label memory read strobe
//   lbl_data     label memory read data, valid the cycle after lbl_rd
//   busy         high whenever a vote is in progress or a result is pending
//   class_out    winning class, held until the next result
//   class_valid  result valid, held until class_ack
//   class_ack    result consumed
module knn_vote #(
  parameter int K     = 4,
  parameter int IDX_W = 8,
  parameter int LBL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       sel,
  input  logic [IDX_W-1:0] idx_in,
  output logic [IDX_W-1:0] lbl_addr,
  output logic             lbl_rd,
  input  logic [LBL_W-1:0] lbl_data,
  output logic             busy,
  output logic [LBL_W-1:0] class_out,
  output logic             class_valid,
  input  logic             class_ack
);

  localparam int NCLASS = 1 << LBL_W;
  localparam int CNT_W  = $clog2(K + 1);
  localparam logic [1:0] LAST_SLOT = 2'(K - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       i;
  logic [LBL_W-1:0] c;
  logic [LBL_W-1:0] best_cls;
  logic [CNT_W-1:0] best_cnt;
  logic [CNT_W-1:0] cnt [NCLASS];
  logic             pend;

  logic             last_slot;
  logic             last_cls;
  logic             win;
  logic [LBL_W-1:0] best_cls_nxt;

  assign last_slot    = (i == LAST_SLOT);
  assign last_cls     = (c == {LBL_W{1'b1}});
  // Strict compare keeps the earliest (lowest) class on a tie.
  assign win          = (cnt[c] > best_cnt);
  assign best_cls_nxt = win ? c : best_cls;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = READ;
      READ:    if (last_slot) state_nxt = DRAIN;
      DRAIN:                  state_nxt = SCAN;
      SCAN:    if (last_cls)  state_nxt = DONE;
      DONE:    if (class_ack) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sel         = 2'd0;
    lbl_addr    = '0;
    lbl_rd      = 1'b0;
    busy        = (state != IDLE);
    class_valid = (state == DONE);
    if (state == READ) begin
      sel      = i;
      lbl_addr = idx_in;
      lbl_rd   = 1'b1;
    end
  end

  // Datapath: slot walk, tally one cycle behind each read, then class scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i         <= 2'd0;
      c         <= '0;
      best_cls  <= '0;
      best_cnt  <= '0;
      pend      <= 1'b0;
      class_out <= '0;
      for (int n = 0; n < NCLASS; n++) cnt[n] <= '0;
    end else begin
      pend <= (state == READ);
      case (state)
        IDLE: begin
          if (start) begin
            i        <= 2'd0;
            c        <= '0;
            best_cls <= '0;
            best_cnt <= '0;
            for (int n = 0; n < NCLASS; n++) cnt[n] <= '0;
          end
        end
        READ:  i <= i + 2'd1;
        DRAIN: c <= '0;
        SCAN: begin
          if (win) begin
            best_cnt <= cnt[c];
            best_cls <= c;
          end
          c <= c + LBL_W'(1);
          // Publish the final winner, including this cycle's comparison.
          if (last_cls) class_out <= best_cls_nxt;
        end
        default: ;
      endcase
      // Label returned for the previous cycle's read; counts never exceed K.
      if (pend) cnt[lbl_data] <= cnt[lbl_data] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed bench for knn_vote with a behavioural sorter
// (idx_in looked up from sel) and a one-cycle-latency label memory.
module tb_knn_vote;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel;
  logic [7:0] idx_in;
  logic [7:0] lbl_addr;
  logic       lbl_rd;
  logic [3:0] lbl_data = 4'd0;
  logic       busy;
  logic [3:0] class_out;
  logic       class_valid;
  logic       class_ack = 1'b0;

  logic [7:0] idx_tbl [4];
  logic [3:0] mem [256];

  int errors = 0;
  int checks = 0;

  knn_vote #(.K(4), .IDX_W(8), .LBL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sel        (sel),
    .idx_in     (idx_in),
    .lbl_addr   (lbl_addr),
    .lbl_rd     (lbl_rd),
    .lbl_data   (lbl_data),
    .busy       (busy),
    .class_out  (class_out),
    .class_valid(class_valid),
    .class_ack  (class_ack)
  );

  always #5 clk = ~clk;

  assign idx_in = idx_tbl[sel];

  always @(posedge clk) begin
    if (lbl_rd) lbl_data <= mem[lbl_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_addr"}, 32'(lbl_addr), 32'd0);
    chk({tag, "_rd"}, 32'(lbl_rd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_class_out"}, 32'(class_out), 32'd0);
    chk({tag, "_valid"}, 32'(class_valid), 32'd0);
  endtask

  // Load neighbour indices and their labels.
  task automatic load(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic [3:0] l0, input logic [3:0] l1,
                      input logic [3:0] l2, input logic [3:0] l3);
    idx_tbl[0] = a0; idx_tbl[1] = a1; idx_tbl[2] = a2; idx_tbl[3] = a3;
    mem[a0] = l0; mem[a1] = l1; mem[a2] = l2; mem[a3] = l3;
  endtask

  // Called at a negedge with the DUT idle: pulses start, waits (bounded) for
  // class_valid and checks latency and winner. Optionally checks the slot walk.
  task automatic vote(input string tag, input logic [3:0] exp_cls, input bit chk_walk,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                      input logic [7:0] e3);
    int lat;
    logic [7:0] exp_addr [4];
    exp_addr[0] = e0; exp_addr[1] = e1; exp_addr[2] = e2; exp_addr[3] = e3;
    lat = 0;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (chk_walk && n <= 4) begin
        chk({tag, "_sel"}, 32'(sel), 32'(n - 1));
        chk({tag, "_addr"}, 32'(lbl_addr), 32'(exp_addr[n-1]));
        chk({tag, "_rd"}, 32'(lbl_rd), 32'd1);
      end
      if (class_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd22);
    chk({tag, "_class"}, 32'(class_out), 32'(exp_cls));
  endtask

  // Ack at a negedge; busy must be low one edge later.
  task automatic ack(input string tag, input logic [3:0] held_cls);
    class_ack = 1'b1;
    @(negedge clk);
    class_ack = 1'b0;
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_valid_fall"}, 32'(class_valid), 32'd0);
    chk({tag, "_class_held"}, 32'(class_out), 32'(held_cls));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 4'd0;
    idx_tbl[0] = 8'd0; idx_tbl[1] = 8'd0; idx_tbl[2] = 8'd0; idx_tbl[3] = 8'd0;

    // Reset state
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Majority 3,3,5,7 -> 3
    load(8'h11, 8'h52, 8'hA3, 8'hF4, 4'd3, 4'd3, 4'd5, 4'd7);
    vote("maj", 4'd3, 1'b0, 8'h11, 8'h52, 8'hA3, 8'hF4);
    ack("maj", 4'd3);

    // Tie 9,2,9,2 -> lowest class 2
    load(8'h21, 8'h22, 8'h23, 8'h24, 4'd9, 4'd2, 4'd9, 4'd2);
    vote("tie", 4'd2, 1'b0, 8'h21, 8'h22, 8'h23, 8'h24);
    ack("tie", 4'd2);

    // All distinct 6,1,4,8 -> 1, with slot walk checked
    load(8'h30, 8'h47, 8'h9C, 8'hE5, 4'd6, 4'd1, 4'd4, 4'd8);
    vote("distinct", 4'd1, 1'b1, 8'h30, 8'h47, 8'h9C, 8'hE5);

    // Hold: no ack for 10 cycles while start pulses
    for (int n = 0; n < 10; n++) begin
      start = n[0];
      @(negedge clk);
      chk("hold_valid", 32'(class_valid), 32'd1);
      chk("hold_class", 32'(class_out), 32'd1);
    end
    start = 1'b0;
    ack("hold", 4'd1);
    @(negedge clk);
    chk("hold_no_restart", 32'(busy), 32'd0);

    // Reset in the middle of SCAN
    load(8'h01, 8'h02, 8'h03, 8'h04, 4'd1, 4'd1, 4'd2, 4'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_scan_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Post-reset vote 15,15,15,0 -> 15
    load(8'h60, 8'h61, 8'h62, 8'h63, 4'd15, 4'd15, 4'd15, 4'd0);
    vote("top", 4'd15, 1'b0, 8'h60, 8'h61, 8'h62, 8'h63);
    ack("top", 4'd15);

    // Start in the cycle right after the ack, labels all 0 -> 0
    load(8'h70, 8'h71, 8'h72, 8'h73, 4'd0, 4'd0, 4'd0, 4'd0);
    vote("zero", 4'd0, 1'b0, 8'h70, 8'h71, 8'h72, 8'h73);

    // start coinciding with ack: only the ack takes effect
    start = 1'b1;
    class_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    class_ack = 1'b0;
    chk("ack_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("ack_start_ignored", 32'(busy), 32'd0);

    // Ack while idle is ignored
    class_ack = 1'b1;
    @(negedge clk);
    class_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_class", 32'(class_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
